// File: rtl/uart_tx_sequencer_if.sv
// uart_tx_sequencer_if
//   CPU-side data/status bundle of the UART transmit sequencer.
//   master : CPU/register side, drives BAUDDIV, WDATA, WE, CLROVR.
//   slave  : sequencer side, drives TX, BUSY, EMPTY, FULL, OVR, TXDONE.
interface uart_tx_sequencer_if;
  logic [7:0] BAUDDIV;
  logic [7:0] WDATA;
  logic       WE;
  logic       CLROVR;
  logic       TX;
  logic       BUSY;
  logic       EMPTY;
  logic       FULL;
  logic       OVR;
  logic       TXDONE;

  modport master (
    output BAUDDIV, WDATA, WE, CLROVR,
    input  TX, BUSY, EMPTY, FULL, OVR, TXDONE
  );

  modport slave (
    input  BAUDDIV, WDATA, WE, CLROVR,
    output TX, BUSY, EMPTY, FULL, OVR, TXDONE
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
//   Transmit-side UART controller: byte FIFO, baud down-counter and a
//   start/data/stop frame sequencer.
//   Ports:
//     CLK  - system clock, rising edge
//     RST  - synchronous reset, active-high
//     bus  - uart_tx_sequencer_if.slave (BAUDDIV, WDATA, WE, CLROVR in;
//            TX, BUSY, EMPTY, FULL, OVR, TXDONE out)
//   Build option:
//     PARITY_EN - when defined, an even-parity bit is sent between the
//                 last data bit and the stop bit.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | line idle (TX=1); pops the FIFO head when not empty
//   S_START  | start bit (TX=0)
//   S_DATA   | data bits, LSB first, TX=shift[0]
//   S_PARITY | even parity of the data byte (PARITY_EN builds only)
//   S_STOP   | stop bit (TX=1); TXDONE in its last cycle, may chain
module uart_tx_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_BITS  = 8
) (
  input logic               CLK,
  input logic               RST,
  uart_tx_sequencer_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovr_q, ovr_d;

  state_t               state_q, state_d;
  logic [7:0]           baud_cnt_q, baud_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 txdone_q, txdone_d;
`ifdef PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic [7:0]           head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign bit_end    = (baud_cnt_q == 8'd0);
  assign push       = bus.WE && !fifo_full;

  // Frame sequencer next-state logic
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    tx_d       = tx_q;
    pop        = 1'b0;
`ifdef PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != S_IDLE && !bit_end) begin
      baud_cnt_d = baud_cnt_q - 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        pop  = !fifo_empty;
      end
      S_START: begin
        if (bit_end) begin
          state_d    = S_DATA;
          baud_cnt_d = bus.BAUDDIV;
          tx_d       = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_d = bus.BAUDDIV;
          shift_d    = shift_q >> 1;
          bit_idx_d  = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          baud_cnt_d = bus.BAUDDIV;
          tx_d       = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when data is waiting.
          pop     = !fifo_empty;
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      state_d    = S_START;
      shift_d    = head[DATA_BITS-1:0];
      bit_idx_d  = '0;
      baud_cnt_d = bus.BAUDDIV;
      tx_d       = 1'b0;
`ifdef PARITY_EN
      parity_d   = ^head[DATA_BITS-1:0];
`endif
    end

    busy_d   = (state_d != S_IDLE);
    // Registered pulse: high exactly while the stop counter reads 0.
    txdone_d = (state_d == S_STOP) && (baud_cnt_d == 8'd0);
  end

  // FIFO bookkeeping
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovr_d    = ovr_q;

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // A dropped write wins over a simultaneous clear.
    if (bus.WE && fifo_full) begin
      ovr_d = 1'b1;
    end else if (bus.CLROVR) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= 8'd0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      txdone_q   <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovr_q      <= 1'b0;
`ifdef PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      txdone_q   <= txdone_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovr_q      <= ovr_d;
`ifdef PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.WDATA;
    end
  end

  assign bus.TX     = tx_q;
  assign bus.BUSY   = busy_q;
  assign bus.TXDONE = txdone_q;
  assign bus.EMPTY  = fifo_empty;
  assign bus.FULL   = fifo_full;
  assign bus.OVR    = ovr_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
module tb_uart_tx_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  uart_tx_sequencer_if u_if ();

  uart_tx_sequencer #(
    .FIFO_DEPTH (4),
    .DATA_BITS  (8)
  ) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (u_if.TX !== 1'b1 || u_if.BUSY !== 1'b0 || u_if.EMPTY !== 1'b1 ||
          u_if.FULL !== 1'b0 || u_if.OVR !== 1'b0 || u_if.TXDONE !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got TX=%b BUSY=%b EMPTY=%b FULL=%b OVR=%b TXDONE=%b exp 1 0 1 0 0 0",
                 i, u_if.TX, u_if.BUSY, u_if.EMPTY, u_if.FULL, u_if.OVR, u_if.TXDONE);
      end
      tick();
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    u_if.BAUDDIV = 8'd3;
    u_if.WDATA   = 8'hA5;
    u_if.WE      = 1'b1;
    tick();
    u_if.WE = 1'b0;
    checks++;
    if (u_if.TX !== 1'b1 || u_if.BUSY !== 1'b0 || u_if.EMPTY !== 1'b0) begin
      errors++;
      $display("FAIL single_pre got TX=%b BUSY=%b EMPTY=%b exp 1 0 0", u_if.TX, u_if.BUSY, u_if.EMPTY);
    end
    tick();
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (u_if.TX !== frame[i/4] || u_if.BUSY !== 1'b1 || u_if.TXDONE !== (i == 39)) begin
        errors++;
        $display("FAIL single_frame cycle %0d got TX=%b BUSY=%b TXDONE=%b exp %b 1 %b",
                 i, u_if.TX, u_if.BUSY, u_if.TXDONE, frame[i/4], (i == 39));
      end
      tick();
    end
    checks++;
    if (u_if.TX !== 1'b1 || u_if.BUSY !== 1'b0 || u_if.TXDONE !== 1'b0) begin
      errors++;
      $display("FAIL single_post got TX=%b BUSY=%b TXDONE=%b exp 1 0 0", u_if.TX, u_if.BUSY, u_if.TXDONE);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [29:0] frames;
    frames = {1'b1, 8'h55, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    u_if.BAUDDIV = 8'd0;
    u_if.WDATA   = 8'h00;
    u_if.WE      = 1'b1;
    tick();
    u_if.WDATA = 8'hFF;
    checks++;
    if (u_if.BUSY !== 1'b0 || u_if.TX !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pre got BUSY=%b TX=%b exp 0 1", u_if.BUSY, u_if.TX);
    end
    tick();
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (u_if.TX !== frames[i] || u_if.BUSY !== 1'b1 ||
          u_if.TXDONE !== ((i % 10) == 9) || u_if.EMPTY !== (i >= 20)) begin
        errors++;
        $display("FAIL b2b cycle %0d got TX=%b BUSY=%b TXDONE=%b EMPTY=%b exp %b 1 %b %b",
                 i, u_if.TX, u_if.BUSY, u_if.TXDONE, u_if.EMPTY, frames[i], ((i % 10) == 9), (i >= 20));
      end
      if (i == 0) begin
        u_if.WDATA = 8'h55;
      end else if (i == 1) begin
        u_if.WE = 1'b0;
      end
      tick();
    end
    checks++;
    if (u_if.BUSY !== 1'b0 || u_if.TX !== 1'b1 || u_if.EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL b2b_post got BUSY=%b TX=%b EMPTY=%b exp 0 1 1", u_if.BUSY, u_if.TX, u_if.EMPTY);
    end
    tick();
  endtask

  task automatic test_overrun();
    logic [7:0] rx;
    int k, o, bp;
    rx = 8'h00;
    u_if.BAUDDIV = 8'd255;
    for (int t = 0; t <= 12802; t++) begin
      if (t == 5) begin
        checks++;
        if (u_if.FULL !== 1'b1 || u_if.OVR !== 1'b0) begin
          errors++;
          $display("FAIL ovr_full got FULL=%b OVR=%b exp 1 0", u_if.FULL, u_if.OVR);
        end
      end
      if (t == 6) begin
        checks++;
        if (u_if.FULL !== 1'b1 || u_if.OVR !== 1'b1) begin
          errors++;
          $display("FAIL ovr_set got FULL=%b OVR=%b exp 1 1", u_if.FULL, u_if.OVR);
        end
      end
      if (t == 7) begin
        checks++;
        if (u_if.OVR !== 1'b1) begin
          errors++;
          $display("FAIL ovr_clr_vs_drop got OVR=%b exp 1", u_if.OVR);
        end
      end
      if (t == 8) begin
        checks++;
        if (u_if.OVR !== 1'b0) begin
          errors++;
          $display("FAIL ovr_clear got OVR=%b exp 0", u_if.OVR);
        end
      end
      if (t == 2561) begin
        checks++;
        if (u_if.TXDONE !== 1'b1 || u_if.FULL !== 1'b1) begin
          errors++;
          $display("FAIL ovr_pop_edge got TXDONE=%b FULL=%b exp 1 1", u_if.TXDONE, u_if.FULL);
        end
      end
      if (t == 2562) begin
        checks++;
        if (u_if.OVR !== 1'b1 || u_if.FULL !== 1'b0) begin
          errors++;
          $display("FAIL ovr_drop_with_pop got OVR=%b FULL=%b exp 1 0", u_if.OVR, u_if.FULL);
        end
      end
      if (t == 2563) begin
        checks++;
        if (u_if.OVR !== 1'b0) begin
          errors++;
          $display("FAIL ovr_clear2 got OVR=%b exp 0", u_if.OVR);
        end
      end
      if (t >= 2 && t < 12802) begin
        k = (t - 2) / 2560;
        o = (t - 2) % 2560;
        if ((o % 256) == 128) begin
          bp = o / 256;
          if (bp == 0) begin
            checks++;
            if (u_if.TX !== 1'b0) begin
              errors++;
              $display("FAIL ovr_start frame %0d got TX=%b exp 0", k, u_if.TX);
            end
          end else if (bp <= 8) begin
            rx[bp-1] = u_if.TX;
          end else begin
            checks++;
            if (u_if.TX !== 1'b1 || rx !== 8'(k + 1)) begin
              errors++;
              $display("FAIL ovr_byte frame %0d got data=%h stop=%b exp %h 1", k, rx, u_if.TX, 8'(k + 1));
            end
          end
        end
      end
      if (t == 12802) begin
        checks++;
        if (u_if.BUSY !== 1'b0 || u_if.EMPTY !== 1'b1 || u_if.OVR !== 1'b0) begin
          errors++;
          $display("FAIL ovr_end got BUSY=%b EMPTY=%b OVR=%b exp 0 1 0", u_if.BUSY, u_if.EMPTY, u_if.OVR);
        end
      end
      u_if.WE     = (t <= 6) || (t == 2561);
      u_if.WDATA  = (t <= 5) ? 8'(t + 1) : ((t == 6) ? 8'h77 : 8'h99);
      u_if.CLROVR = (t == 6) || (t == 7) || (t == 2562);
      tick();
    end
    u_if.WE     = 1'b0;
    u_if.CLROVR = 1'b0;
  endtask

  task automatic test_reset_midframe();
    u_if.BAUDDIV = 8'd7;
    u_if.WDATA   = 8'h3C;
    u_if.WE      = 1'b1;
    tick();
    u_if.WE = 1'b0;
    tick();
    checks++;
    if (u_if.TX !== 1'b0 || u_if.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL mid_start got TX=%b BUSY=%b exp 0 1", u_if.TX, u_if.BUSY);
    end
    for (int i = 0; i < 34; i++) tick();
    checks++;
    if (u_if.TX !== 1'b1 || u_if.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL mid_bit3 got TX=%b BUSY=%b exp 1 1", u_if.TX, u_if.BUSY);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (u_if.TX !== 1'b1 || u_if.BUSY !== 1'b0 || u_if.EMPTY !== 1'b1 || u_if.TXDONE !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got TX=%b BUSY=%b EMPTY=%b TXDONE=%b exp 1 0 1 0",
               u_if.TX, u_if.BUSY, u_if.EMPTY, u_if.TXDONE);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (u_if.TXDONE !== 1'b0 || u_if.BUSY !== 1'b0 || u_if.TX !== 1'b1) begin
        errors++;
        $display("FAIL mid_after cycle %0d got TXDONE=%b BUSY=%b TX=%b exp 0 0 1",
                 i, u_if.TXDONE, u_if.BUSY, u_if.TX);
      end
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [7:0]  bytes [2];
    logic        pbits [2];
    logic [10:0] frame;
    bytes[0] = 8'h07; pbits[0] = 1'b1;
    bytes[1] = 8'h03; pbits[1] = 1'b0;
    u_if.BAUDDIV = 8'd1;
    for (int b = 0; b < 2; b++) begin
      frame = {1'b1, pbits[b], bytes[b], 1'b0};
      u_if.WDATA = bytes[b];
      u_if.WE    = 1'b1;
      tick();
      u_if.WE = 1'b0;
      tick();
      for (int i = 0; i < 22; i++) begin
        checks++;
        if (u_if.TX !== frame[i/2] || u_if.BUSY !== 1'b1 || u_if.TXDONE !== (i == 21)) begin
          errors++;
          $display("FAIL parity byte %h cycle %0d got TX=%b BUSY=%b TXDONE=%b exp %b 1 %b",
                   bytes[b], i, u_if.TX, u_if.BUSY, u_if.TXDONE, frame[i/2], (i == 21));
        end
        tick();
      end
      checks++;
      if (u_if.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL parity_end byte %h got BUSY=%b exp 0", bytes[b], u_if.BUSY);
      end
      tick();
    end
  endtask
`endif

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    u_if.BAUDDIV = 8'd0;
    u_if.WDATA   = 8'h00;
    u_if.WE      = 1'b0;
    u_if.CLROVR  = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
Transmit-side controller for the serial peripheral. It buffers bytes written through the CPU data-register path in a small FIFO and generates the baud tick from the 8-bit baud divisor register value. It sequences each byte onto TX as a start/data/stop frame and reports FIFO and busy status for the status register and interrupt logic.

Parameters:
FIFO_DEPTH, 4, number of byte slots in the TX FIFO; power of two, 2..16.
DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
RST  input  1  synchronous reset, active-high.
BAUDDIV  input  8  baud divisor; each bit period is BAUDDIV+1 CLK cycles.
WDATA  input  8  byte to enqueue.
WE  input  1  enqueue strobe, one byte per cycle when high.
CLROVR  input  1  clears the OVR flag.
TX  output  1  serial output; idle level is 1.
BUSY  output  1  high while a frame is in progress (any state other than IDLE).
EMPTY  output  1  FIFO holds 0 bytes.
FULL  output  1  FIFO holds FIFO_DEPTH bytes.
OVR  output  1  sticky overrun flag: a write was attempted while FULL.
TXDONE  output  1  one-cycle pulse in the last cycle of a stop bit.

Behaviour:
- Reset (RST=1 at an edge):
  - FIFO emptied; state goes to IDLE.
  - TX=1, BUSY=0, EMPTY=1, FULL=0, OVR=0, TXDONE=0.
  - Applies mid-frame: the frame is aborted and TX returns to 1 on the next cycle.
- FIFO:
  - Circular buffer with read/write pointers and a count register of width clog2(FIFO_DEPTH)+1.
  - FULL and EMPTY decode the registered count.
  - WE with FULL=0: WDATA is stored and count increments, unless a pop occurs in the same cycle, in which case count is unchanged.
  - WE with FULL=1: the byte is dropped and OVR is set, even if a pop occurs in the same cycle.
  - CLROVR=1 clears OVR. If CLROVR and a dropped write occur in the same cycle, OVR stays set.
  - Pointers wrap modulo FIFO_DEPTH.
- Baud counter:
  - 8-bit down-counter, loaded with BAUDDIV on entry to every bit.
  - A bit ends in the cycle the counter reads 0.
  - BAUDDIV=0 gives one-cycle bits.
  - BAUDDIV is resampled at every bit load; software changes BAUDDIV only while BUSY=0.
- FSM states: IDLE, START, DATA, STOP (PARITY with the optional feature).
  - IDLE: TX=1. If EMPTY=0: pop the FIFO head into the shift register, set the bit index to 0, load the counter, and go to START on the next cycle.
  - START: TX=0 for BAUDDIV+1 cycles, then DATA.
  - DATA: TX=shift[0] for each bit period. At each bit end, shift right and increment the index. After bit DATA_BITS-1, go to STOP.
  - STOP: TX=1 for BAUDDIV+1 cycles. TXDONE=1 in the final cycle. If EMPTY=0 in that cycle, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Frame timing:
  - Frame length is (DATA_BITS+2)*(BAUDDIV+1) cycles.
  - The first START cycle is 2 cycles after the WE that fills an empty FIFO while IDLE.
- TX, BUSY and TXDONE are registered outputs (no combinational path from inputs).

Optional Feature:
PARITY_EN:
- Defined: a PARITY state sits between DATA and STOP and lasts BAUDDIV+1 cycles. TX carries the even parity of the data byte (XOR of all data bits). Frame length is (DATA_BITS+3)*(BAUDDIV+1).
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
- Reset then idle: with RST held for 2 cycles and no WE for 20 cycles, TX=1, BUSY=0, EMPTY=1, FULL=0, OVR=0 throughout.
- Single frame: BAUDDIV=3, WE with 0xA5 → TX sequence is 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each held 4 cycles (40 cycles total). TXDONE pulses once in cycle 40; BUSY falls the cycle after.
- Back-to-back frames: BAUDDIV=0, write 0x00, 0xFF, 0x55 on consecutive cycles → 30 contiguous frame cycles with no idle gap and 3 TXDONE pulses 10 cycles apart. EMPTY=1 after the third pop.
- Overrun: BAUDDIV=255, write 6 bytes 0x01..0x06 with FIFO_DEPTH=4 → the first byte is popped and 0x02..0x05 are stored. FULL=1, 0x06 is dropped and OVR=1. CLROVR → OVR=0; the transmitted bytes are 0x01..0x05.
- Reset mid-frame: BAUDDIV=7, write 0x3C, assert RST during the 4th data bit → TX=1 and BUSY=0 the next cycle, FIFO empty, and no TXDONE pulse.
- PARITY_EN: BAUDDIV=1, write 0x07 → parity bit 1 is held for 2 cycles before stop. Writing 0x03 gives parity bit 0. Frame length is 22 cycles.
